// File: rtl/blit_walker.sv
// blit_walker
//
// Rectangle walker for the front of the blitter pipeline. It takes one blit
// command and walks the destination rectangle in raster order, presenting one
// pixel per non-stalled cycle on the p1 bus: the destination byte address, the
// source address (image pixel or glyph byte), and the text-stage fields.
//
// Optional feature macro: BLIT_CLIP_EN
//   When defined, clip_x0/clip_y0/clip_x1/clip_y1 form an inclusive clip window
//   in rectangle-relative coordinates. Pixels outside it are still walked, one
//   cycle each, but are presented with p1_valid=0.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   stall               freezes all state and the p1 outputs
//   cmd_valid/cmd_ready command handshake (see below)
//   cmd_*               command fields, latched on accept
//   busy                command in progress
//   p1_valid, p1_last   pixel present / final position of the command
//   p1_dst_addr         destination byte address
//   p1_src_addr         source address (text mode: glyph-row byte, no char offset)
//   p1_bit_index        bit within the glyph byte in text mode, else 0
//   p1_char, p1_font_bpc, p1_textmode  latched command copies
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is high exactly while the walker is idle and does not depend on
// stall. A p1 pixel is consumed on each rising edge where p1 carries a walked
// position and stall is low; while stall is high the same pixel is held.
module blit_walker (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_dst_addr,
    input  logic [15:0] cmd_dst_stride,
    input  logic [31:0] cmd_src_addr,
    input  logic [15:0] cmd_src_stride,
    input  logic [15:0] cmd_width,
    input  logic [15:0] cmd_height,
    input  logic        cmd_textmode,
    input  logic [7:0]  cmd_char,
    input  logic [7:0]  cmd_font_bpc,
`ifdef BLIT_CLIP_EN
    input  logic [15:0] clip_x0,
    input  logic [15:0] clip_y0,
    input  logic [15:0] clip_x1,
    input  logic [15:0] clip_y1,
`endif
    output logic        busy,
    output logic        p1_valid,
    output logic        p1_last,
    output logic [31:0] p1_dst_addr,
    output logic [31:0] p1_src_addr,
    output logic [2:0]  p1_bit_index,
    output logic [7:0]  p1_char,
    output logic [7:0]  p1_font_bpc,
    output logic        p1_textmode
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [31:0] row_dst_q, row_dst_d;
    logic [31:0] row_src_q, row_src_d;
    logic [15:0] dst_stride_q, dst_stride_d;
    logic [15:0] src_stride_q, src_stride_d;
    logic [15:0] width_q, width_d;
    logic [15:0] height_q, height_d;
    logic        textmode_q, textmode_d;
    logic [7:0]  char_q, char_d;
    logic [7:0]  bpc_q, bpc_d;

    logic row_end;
    logic rect_end;
    logic in_clip;

    assign row_end  = (x_q == width_q - 16'd1);
    assign rect_end = row_end && (y_q == height_q - 16'd1);

`ifdef BLIT_CLIP_EN
    assign in_clip = (x_q >= clip_x0) && (x_q <= clip_x1) &&
                     (y_q >= clip_y0) && (y_q <= clip_y1);
`else
    assign in_clip = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        row_dst_d    = row_dst_q;
        row_src_d    = row_src_q;
        dst_stride_d = dst_stride_q;
        src_stride_d = src_stride_q;
        width_d      = width_q;
        height_d     = height_q;
        textmode_d   = textmode_q;
        char_d       = char_q;
        bpc_d        = bpc_q;

        case (state_q)
            IDLE: begin
                // An empty rectangle is accepted but leaves every register
                // untouched, so the p1 fields keep showing the last pixel.
                if (cmd_valid && (cmd_width != 16'd0) && (cmd_height != 16'd0)) begin
                    state_d      = RUN;
                    x_d          = 16'd0;
                    y_d          = 16'd0;
                    row_dst_d    = cmd_dst_addr;
                    row_src_d    = cmd_src_addr;
                    dst_stride_d = cmd_dst_stride;
                    src_stride_d = cmd_src_stride;
                    width_d      = cmd_width;
                    height_d     = cmd_height;
                    textmode_d   = cmd_textmode;
                    char_d       = cmd_char;
                    bpc_d        = cmd_font_bpc;
                end
            end
            RUN: begin
                if (!stall) begin
                    // The final position does not advance the counters, so
                    // the p1 data fields hold their last values once idle.
                    if (rect_end) begin
                        state_d = IDLE;
                    end else if (row_end) begin
                        x_d       = 16'd0;
                        y_d       = y_q + 16'd1;
                        row_dst_d = row_dst_q + {16'h0000, dst_stride_q};
                        row_src_d = row_src_q + {16'h0000, src_stride_q};
                    end else begin
                        x_d = x_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= 16'd0;
            y_q          <= 16'd0;
            row_dst_q    <= 32'd0;
            row_src_q    <= 32'd0;
            dst_stride_q <= 16'd0;
            src_stride_q <= 16'd0;
            width_q      <= 16'd0;
            height_q     <= 16'd0;
            textmode_q   <= 1'b0;
            char_q       <= 8'd0;
            bpc_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            row_dst_q    <= row_dst_d;
            row_src_q    <= row_src_d;
            dst_stride_q <= dst_stride_d;
            src_stride_q <= src_stride_d;
            width_q      <= width_d;
            height_q     <= height_d;
            textmode_q   <= textmode_d;
            char_q       <= char_d;
            bpc_q        <= bpc_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign p1_valid  = (state_q == RUN) && in_clip;
    assign p1_last   = (state_q == RUN) && rect_end;

    // In text mode eight horizontal pixels share one glyph byte.
    assign p1_dst_addr  = row_dst_q + {16'h0000, x_q};
    assign p1_src_addr  = textmode_q ? (row_src_q + {19'h00000, x_q[15:3]})
                                     : (row_src_q + {16'h0000, x_q});
    assign p1_bit_index = textmode_q ? x_q[2:0] : 3'd0;
    assign p1_char      = char_q;
    assign p1_font_bpc  = bpc_q;
    assign p1_textmode  = textmode_q;

endmodule

// File: tb/tb_blit_walker.sv
// Self-checking bench for blit_walker: reset values, a table of commands
// compared pixel by pixel against a raster model, and hand-written sequences
// for stall hold, empty rectangles, reset mid-command and (with BLIT_CLIP_EN)
// clipping.
module tb_blit_walker;

    logic        clock = 1'b0;
    logic        reset, stall, cmd_valid, cmd_ready;
    logic [31:0] cmd_dst_addr, cmd_src_addr;
    logic [15:0] cmd_dst_stride, cmd_src_stride, cmd_width, cmd_height;
    logic        cmd_textmode;
    logic [7:0]  cmd_char, cmd_font_bpc;
    logic        busy, p1_valid, p1_last, p1_textmode;
    logic [31:0] p1_dst_addr, p1_src_addr;
    logic [2:0]  p1_bit_index;
    logic [7:0]  p1_char, p1_font_bpc;
    logic [15:0] cx0 = 16'd0, cy0 = 16'd0, cx1 = 16'hFFFF, cy1 = 16'hFFFF;

    always #5 clock = ~clock;

    blit_walker dut (
        .clock(clock), .reset(reset), .stall(stall),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dst_addr(cmd_dst_addr), .cmd_dst_stride(cmd_dst_stride),
        .cmd_src_addr(cmd_src_addr), .cmd_src_stride(cmd_src_stride),
        .cmd_width(cmd_width), .cmd_height(cmd_height),
        .cmd_textmode(cmd_textmode), .cmd_char(cmd_char), .cmd_font_bpc(cmd_font_bpc),
`ifdef BLIT_CLIP_EN
        .clip_x0(cx0), .clip_y0(cy0), .clip_x1(cx1), .clip_y1(cy1),
`endif
        .busy(busy), .p1_valid(p1_valid), .p1_last(p1_last),
        .p1_dst_addr(p1_dst_addr), .p1_src_addr(p1_src_addr),
        .p1_bit_index(p1_bit_index), .p1_char(p1_char),
        .p1_font_bpc(p1_font_bpc), .p1_textmode(p1_textmode)
    );

    typedef struct {
        logic [31:0] dst;
        logic [15:0] dstr;
        logic [31:0] src;
        logic [15:0] sstr;
        logic [15:0] w;
        logic [15:0] h;
        logic        text;
        logic [7:0]  ch;
        logic [7:0]  bpc;
        logic        rnd_stall;
        int          exp_pixels;
        logic [31:0] exp_last_dst;
        logic [31:0] exp_last_src;
    } vec_t;

    // {last, dst, src, bit_index, char, font_bpc, textmode}
    logic [84:0] exp_q[$];
    vec_t        vecs[6];
    int          checks = 0;
    int          failures = 0;
    int          pix_cnt;
    logic [31:0] last_dst, last_src;
    logic        ready_seen;
    logic        rand_stall_en = 1'b0;

    function automatic vec_t mkv(logic [31:0] dst, logic [15:0] dstr, logic [31:0] src,
                                 logic [15:0] sstr, logic [15:0] w, logic [15:0] h,
                                 logic text, logic [7:0] ch, logic [7:0] bpc, logic rnd,
                                 int np, logic [31:0] ld, logic [31:0] ls);
        vec_t v;
        v.dst = dst; v.dstr = dstr; v.src = src; v.sstr = sstr; v.w = w; v.h = h;
        v.text = text; v.ch = ch; v.bpc = bpc; v.rnd_stall = rnd;
        v.exp_pixels = np; v.exp_last_dst = ld; v.exp_last_src = ls;
        return v;
    endfunction

    task automatic check(input string name, input logic [84:0] act, input logic [84:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Raster model: addresses from y*stride products rather than running sums.
    task automatic push_model(input vec_t v);
        for (int y = 0; y < int'(v.h); y++) begin
            for (int x = 0; x < int'(v.w); x++) begin
                logic [31:0] d, s, xo;
                logic [2:0]  b;
                logic        l;
                xo = v.text ? 32'(x >> 3) : 32'(x);
                d  = v.dst + (32'(y) * {16'h0, v.dstr}) + 32'(x);
                s  = v.src + (32'(y) * {16'h0, v.sstr}) + xo;
                b  = v.text ? 3'(x % 8) : 3'd0;
                l  = (x == int'(v.w) - 1) && (y == int'(v.h) - 1);
                if (x >= int'(cx0) && x <= int'(cx1) && y >= int'(cy0) && y <= int'(cy1))
                    exp_q.push_back({l, d, s, b, v.ch, v.bpc, v.text});
            end
        end
    endtask

    // Negedge half of a cycle: scoreboard compare of any pixel consumed next edge.
    task automatic at_neg();
        @(negedge clock);
        ready_seen = cmd_ready;
        if (p1_valid && !stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pixel actual_dst=%0h expected=none", p1_dst_addr);
            end else begin
                check("pixel", {p1_last, p1_dst_addr, p1_src_addr, p1_bit_index,
                                p1_char, p1_font_bpc, p1_textmode}, exp_q.pop_front());
            end
            pix_cnt++;
            if (p1_last) begin
                last_dst = p1_dst_addr;
                last_src = p1_src_addr;
            end
        end
    endtask

    task automatic at_pos();
        @(posedge clock);
        #1;
        if (rand_stall_en) stall = ($urandom_range(0, 3) == 0);
    endtask

    task automatic tick();
        at_neg();
        at_pos();
    endtask

    task automatic send(input vec_t v);
        int n;
        cmd_dst_addr = v.dst; cmd_dst_stride = v.dstr;
        cmd_src_addr = v.src; cmd_src_stride = v.sstr;
        cmd_width = v.w; cmd_height = v.h; cmd_textmode = v.text;
        cmd_char = v.ch; cmd_font_bpc = v.bpc;
        cmd_valid = 1'b1;
        push_model(v);
        n = 0;
        ready_seen = 1'b0;
        while (!ready_seen && n < 200) begin
            tick();
            n++;
        end
        if (!ready_seen) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=not_ready expected=ready");
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_left expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; cmd_valid = 1'b0;
        cmd_dst_addr = '0; cmd_dst_stride = '0; cmd_src_addr = '0; cmd_src_stride = '0;
        cmd_width = '0; cmd_height = '0; cmd_textmode = 1'b0; cmd_char = '0; cmd_font_bpc = '0;
        pix_cnt = 0; last_dst = '0; last_src = '0;

        vecs[0] = mkv(32'h1000, 16'h100, 32'h2000, 16'h40, 16'd3, 16'd2, 1'b0, 8'h00, 8'h00,
                      1'b0, 6, 32'h1102, 32'h2042);
        vecs[1] = mkv(32'h3000, 16'h20, 32'h8000, 16'd2, 16'd10, 16'd2, 1'b1, 8'h41, 8'd16,
                      1'b0, 20, 32'h3029, 32'h8003);
        vecs[2] = mkv(32'hFFFF_FFFE, 16'h0, 32'h10, 16'h0, 16'd4, 16'd1, 1'b0, 8'h00, 8'h00,
                      1'b0, 4, 32'h0000_0001, 32'h13);
        vecs[3] = mkv(32'h4000, 16'h10, 32'h5000, 16'h8, 16'd5, 16'd3, 1'b0, 8'h07, 8'h09,
                      1'b1, 15, 32'h4024, 32'h5014);
        vecs[4] = mkv(32'h100, 16'h40, 32'hFFFF_FFFF, 16'd3, 16'd17, 16'd2, 1'b1, 8'h5A, 8'd8,
                      1'b1, 34, 32'h150, 32'h4);
        vecs[5] = mkv(32'h0, 16'hFFFF, 32'h0, 16'hFFFF, 16'd2, 16'd2, 1'b0, 8'h00, 8'h00,
                      1'b0, 4, 32'h10000, 32'h10000);

        // Reset values.
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        at_neg();
        check("rst_cmd_ready", 85'(cmd_ready), 85'(1));
        check("rst_busy", 85'(busy), 85'(0));
        check("rst_p1_valid", 85'(p1_valid), 85'(0));
        check("rst_p1_last", 85'(p1_last), 85'(0));
        check("rst_p1_fields", {p1_dst_addr, p1_src_addr, p1_bit_index, p1_char,
                                p1_font_bpc, p1_textmode}, 85'(0));
        at_pos();

        // Table of commands.
        for (int i = 0; i < 6; i++) begin
            pix_cnt = 0;
            rand_stall_en = vecs[i].rnd_stall;
            send(vecs[i]);
            wait_done();
            rand_stall_en = 1'b0;
            stall = 1'b0;
            check($sformatf("vec%0d_count", i), 85'(pix_cnt), 85'(vecs[i].exp_pixels));
            check($sformatf("vec%0d_last_dst", i), 85'(last_dst), 85'(vecs[i].exp_last_dst));
            check($sformatf("vec%0d_last_src", i), 85'(last_src), 85'(vecs[i].exp_last_src));
            at_neg();
            check($sformatf("vec%0d_ready_after", i), 85'(cmd_ready), 85'(1));
            check($sformatf("vec%0d_busy_after", i), 85'(busy), 85'(0));
            at_pos();
        end

        // Stall held three cycles on the second pixel of a 4x1 blit.
        pix_cnt = 0;
        send(mkv(32'h600, 16'h0, 32'h700, 16'h0, 16'd4, 16'd1, 1'b0, 8'h00, 8'h00,
                 1'b0, 4, 32'h603, 32'h703));
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            check("stall_hold_valid", 85'(p1_valid), 85'(1));
            check("stall_hold_dst", 85'(p1_dst_addr), 85'(32'h601));
            check("stall_hold_src", 85'(p1_src_addr), 85'(32'h701));
            at_pos();
        end
        stall = 1'b0;
        wait_done();
        check("stall_count", 85'(pix_cnt), 85'(4));
        check("stall_last_dst", 85'(last_dst), 85'(32'h603));

        // Empty rectangle: accepted, nothing walked.
        pix_cnt = 0;
        send(mkv(32'h9000, 16'h10, 32'hA000, 16'h10, 16'd0, 16'd5, 1'b0, 8'h00, 8'h00,
                 1'b0, 0, 32'h0, 32'h0));
        at_neg();
        check("empty_busy", 85'(busy), 85'(0));
        check("empty_ready", 85'(cmd_ready), 85'(1));
        check("empty_valid", 85'(p1_valid), 85'(0));
        at_pos();
        repeat (3) tick();
        check("empty_count", 85'(pix_cnt), 85'(0));

        // Reset in the middle of a 16x16 blit, then a 1x1 command.
        send(mkv(32'h0, 16'h10, 32'h0, 16'h10, 16'd16, 16'd16, 1'b0, 8'h00, 8'h00,
                 1'b0, 256, 32'h0, 32'h0));
        repeat (10) tick();
        reset = 1'b1;
        tick();
        exp_q.delete();
        reset = 1'b0;
        at_neg();
        check("midrst_valid", 85'(p1_valid), 85'(0));
        check("midrst_ready", 85'(cmd_ready), 85'(1));
        check("midrst_busy", 85'(busy), 85'(0));
        at_pos();
        pix_cnt = 0;
        last_dst = '0;
        send(mkv(32'hC0DE, 16'h0, 32'hBEEF, 16'h0, 16'd1, 16'd1, 1'b0, 8'h00, 8'h00,
                 1'b0, 1, 32'hC0DE, 32'hBEEF));
        wait_done();
        repeat (2) tick();
        check("one_px_count", 85'(pix_cnt), 85'(1));
        check("one_px_last_dst", 85'(last_dst), 85'(32'hC0DE));

`ifdef BLIT_CLIP_EN
        // 4x4 walk clipped to (1,1)-(2,2).
        pix_cnt = 0;
        cx0 = 16'd1; cy0 = 16'd1; cx1 = 16'd2; cy1 = 16'd2;
        send(mkv(32'h2000, 16'h10, 32'h3000, 16'h10, 16'd4, 16'd4, 1'b0, 8'h00, 8'h00,
                 1'b0, 4, 32'h0, 32'h0));
        for (int i = 0; i < 16; i++) begin
            logic ev;
            ev = ((i % 4) >= 1) && ((i % 4) <= 2) && ((i / 4) >= 1) && ((i / 4) <= 2);
            at_neg();
            check("clip_valid", 85'(p1_valid), 85'(ev));
            check("clip_last", 85'(p1_last), 85'(i == 15));
            at_pos();
        end
        at_neg();
        check("clip_idle", 85'(busy), 85'(0));
        at_pos();
        check("clip_count", 85'(pix_cnt), 85'(4));
        check("clip_queue_empty", 85'(exp_q.size()), 85'(0));
        cx0 = 16'd0; cy0 = 16'd0; cx1 = 16'hFFFF; cy1 = 16'hFFFF;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/blit_walker.md
# blit_walker

Rectangle walker feeding the first stage of the blitter pipeline. It accepts one blit command and steps through the destination rectangle in raster order, one pixel per non-stalled cycle. For each pixel it drives a destination address and a source address on the p1 bus, plus the character, font and bit-index fields consumed by the text-address stage. It holds its outputs whenever the pipeline stall is asserted.

## Interface
Parameters: none.

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall; freezes all state and p1 outputs
- cmd_valid  in  1  command present
- cmd_ready  out  1  walker idle, command accepted this cycle if cmd_valid
- cmd_dst_addr  in  32  byte address of the rectangle's top-left destination pixel
- cmd_dst_stride  in  16  destination row pitch in bytes
- cmd_src_addr  in  32  image mode: top-left source pixel; text mode: font base
- cmd_src_stride  in  16  image mode: source pitch; text mode: bytes per glyph row
- cmd_width  in  16  rectangle width in pixels
- cmd_height  in  16  rectangle height in pixels
- cmd_textmode  in  1  1 = text (1 bpp glyph) blit
- cmd_char  in  8  character code (text mode)
- cmd_font_bpc  in  8  font bytes per character (text mode)
- busy  out  1  command in progress
- p1_valid  out  1  p1 fields carry a pixel
- p1_last  out  1  final pixel of the command
- p1_dst_addr  out  32  destination byte address
- p1_src_addr  out  32  source address, before any character offset
- p1_bit_index  out  3  bit within the glyph byte (text mode), else 0
- p1_char, p1_font_bpc  out  8 each  registered command copies
- p1_textmode  out  1  registered command copy

## Operation
- States: IDLE, RUN.
- cmd_ready = (state==IDLE). Accept on cmd_valid && cmd_ready, independent of stall. On accept:
  - latch all command fields;
  - x=0, y=0, row_dst=cmd_dst_addr, row_src=cmd_src_addr;
  - go to RUN.
- Zero width or zero height: the command is accepted, no pixel is emitted, and the walker stays in IDLE.
- Each non-stalled RUN cycle emits the pixel at (x, y):
  - p1_dst_addr = row_dst + x
  - image mode: p1_src_addr = row_src + x, p1_bit_index = 0
  - text mode: p1_src_addr = row_src + (x>>3), p1_bit_index = x[2:0] (MSB-first convention is the expander's concern)
- Advance: if x==width-1, then x=0, y++, row_dst+=dst_stride, row_src+=src_stride; otherwise x++.
- The pixel with x==width-1 and y==height-1 sets p1_last. After it, return to IDLE.
- All address arithmetic is 32-bit and wraps modulo 2^32. Strides are zero-extended.
- busy = (state==RUN).

## Timing
- Reset values: state IDLE, p1_valid 0, p1_last 0, all p1 data fields 0, busy 0, cmd_ready 1.
- Latency: first pixel on p1 in the cycle after accept. Throughput: one pixel per non-stalled cycle.
- stall=1 holds p1 outputs, counters and state unchanged. A held p1 pixel is consumed on the first cycle with stall=0.
- A new command can be accepted in the cycle after the p1_last pixel is consumed. There is no gap beyond that.
- reset while in RUN returns to IDLE next edge and discards the rest of the command. p1_valid=0.
- p1_valid=0 while IDLE. The p1 data fields hold their last values.

## Configuration
- BLIT_CLIP_EN defined:
  - adds inputs clip_x0, clip_y0, clip_x1, clip_y1 (16 bits each), which form an inclusive clip window in rectangle-relative coordinates;
  - pixels outside the window are still walked, each taking one cycle, but are emitted with p1_valid=0;
  - p1_last still pulses on the final position, with p1_valid following the clip test.
- BLIT_CLIP_EN undefined: no clip ports, and every walked pixel has p1_valid=1.

## Test plan
- Image 3x2, dst=0x1000 stride 0x100, src=0x2000 stride 0x40, stall=0 -> dst 0x1000,1001,1002,1100,1101,1102; src 0x2000,2001,2002,2040,2041,2042; p1_last only on 6th; cmd_ready high next cycle.
- Text 10x2, src=0x8000 stride 2, char 0x41, bpc 16 -> src 0x8000 for x0-7 with bit_index 0..7, 0x8001 for x8-9 with bit_index 0,1, row 1 from 0x8002; p1_char=0x41 and p1_font_bpc=16 throughout.
- Stall held 3 cycles on pixel 2 of a 4x1 blit -> p1 fields are unchanged for 3 cycles, and 4 total valid pixels are emitted in order.
- Width 0, height 5 -> no p1_valid, busy never 1, cmd_ready 1 on the next cycle. Also dst=0xFFFFFFFE, width 4 -> dst wraps to 0x00000000, 0x00000001.
- Reset asserted mid-RUN of a 16x16 blit -> IDLE, p1_valid 0, cmd_ready 1 next cycle. A following 1x1 command emits exactly one pixel with p1_last.
- With BLIT_CLIP_EN, 4x4 blit, clip (1,1)-(2,2) -> 16 walked cycles, valid only at (1,1), (2,1), (1,2), (2,2). p1_last on the 16th cycle with p1_valid 0.
